// File: rtl/imem_load_ctrl_pkg.sv
// Shared definitions for the instruction-memory load controller: FSM state
// encoding and the default memory geometry.
package imem_load_ctrl_pkg;

    localparam int IMEM_ADDR_W = 8;
    localparam int IMEM_DEPTH  = 256;
    localparam int WORD_BYTES  = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RUN     = 3'd4
    } imem_state_e;

    // The controller reports busy exactly while memory is being rewritten or handed over.
    function automatic logic state_is_busy(input imem_state_e st);
        return (st == ST_CLEAR) || (st == ST_LOAD) || (st == ST_RELEASE);
    endfunction

endpackage

// File: rtl/imem_fetch_check.sv
// Combinational CPU fetch-address policing: a fetch is illegal when it is not
// word aligned or when the 32-bit word would run past the end of memory.
module imem_fetch_check
    import imem_load_ctrl_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH
) (
    input  logic [31:0] pc_i,
    output logic        illegal_o
);

    localparam logic [31:0] LAST_WORD_ADDR = 32'(DEPTH - WORD_BYTES);

    logic misaligned;
    logic outOfRange;

    assign misaligned = |pc_i[1:0];
    assign outOfRange = (pc_i > LAST_WORD_ADDR);
    assign illegal_o  = misaligned | outOfRange;

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction-memory load controller: zero-fills the memory, writes a streamed
// program from address 0, then releases the CPU and flags illegal fetches.
module imem_load_ctrl
    import imem_load_ctrl_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = IMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [7:0]        mem_wdata,
    input  logic [31:0]       cpu_pc,
    output logic              cpu_rst_n,
    output logic              fetch_err,
    output logic              busy,
    output logic              done
);

    localparam int              CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(DEPTH - 1);

    imem_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic              s_ready_q, s_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              fetch_err_q, fetch_err_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              fetchIllegal;
    logic              handshake;
    logic [CNT_W-1:0]  lenClamped;

    imem_fetch_check #(
        .DEPTH (DEPTH)
    ) u_fetch_check (
        .pc_i      (cpu_pc),
        .illegal_o (fetchIllegal)
    );

    // s_ready_q is only ever high in LOAD, so the handshake needs no state qualifier.
    assign handshake  = s_valid & s_ready_q;
    assign lenClamped = (load_len > DEPTH_C) ? DEPTH_C : load_len;

    // Next-state logic. Every output register is computed one cycle ahead so that
    // what the memory and CPU see always matches the state being entered; cnt_q
    // holds the address written in the current CLEAR cycle or the next LOAD byte.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        s_ready_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rst_n_d = 1'b0;
        fetch_err_d = fetch_err_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d     = ST_CLEAR;
                    len_d       = lenClamped;
                    cnt_d       = '0;
                    mem_we_d    = 1'b1;
                    mem_waddr_d = '0;
                    mem_wdata_d = 8'h00;
                end
            end

            ST_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    cnt_d = '0;
                    if (len_q == '0) begin
                        state_d = ST_RELEASE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = ST_LOAD;
                        s_ready_d = 1'b1;
                    end
                end else begin
                    cnt_d       = cnt_q + 1'b1;
                    mem_we_d    = 1'b1;
                    mem_waddr_d = ADDR_W'(cnt_q + 1'b1);
                    mem_wdata_d = 8'h00;
                end
            end

            ST_LOAD: begin
                s_ready_d = 1'b1;
                if (handshake) begin
                    mem_we_d    = 1'b1;
                    mem_waddr_d = cnt_q[ADDR_W-1:0];
                    mem_wdata_d = s_data;
                    cnt_d       = cnt_q + 1'b1;
                    if (cnt_q == len_q - 1'b1) begin
                        state_d   = ST_RELEASE;
                        s_ready_d = 1'b0;
                        done_d    = 1'b1;
                    end
                end
            end

            ST_RELEASE: begin
                state_d     = ST_RUN;
                cpu_rst_n_d = 1'b1;
            end

            ST_RUN: begin
                cpu_rst_n_d = 1'b1;
                if (load_start) begin
                    state_d     = ST_CLEAR;
                    len_d       = lenClamped;
                    cnt_d       = '0;
                    mem_we_d    = 1'b1;
                    mem_waddr_d = '0;
                    mem_wdata_d = 8'h00;
                    cpu_rst_n_d = 1'b0;
                    fetch_err_d = 1'b0;
                end else if (fetchIllegal) begin
                    fetch_err_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = state_is_busy(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            s_ready_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= 8'h00;
            cpu_rst_n_q <= 1'b0;
            fetch_err_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            s_ready_q   <= s_ready_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            fetch_err_q <= fetch_err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign fetch_err = fetch_err_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: load scenarios and fetch addresses come from
// small tables, with hand-written sequences for reset abort and reprogramming.
module tb_imem_load_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start;
    logic [8:0]  load_len;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [7:0]  mem_wdata;
    logic [31:0] cpu_pc;
    logic        cpu_rst_n;
    logic        fetch_err;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  pat [256];
    logic [7:0]  tbMem [256];
    logic [15:0] wlog [$];
    int          readyCycles;
    int          doneCount;

    logic cpuRstAtDone, busyAtDone, cpuRstAfter, busyAfter, doneAfter;

    typedef struct {
        logic [8:0] len;
        bit         toggle;
        int         expLoadWrites;
        int         expReady;
        logic [7:0] expLastAddr;
    } loadVec_t;

    typedef struct {
        logic [31:0] pc;
        logic        expErr;
    } fetchVec_t;

    loadVec_t  loadVecs [3];
    fetchVec_t fetchVecs [9];

    imem_load_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_len   (load_len),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .cpu_pc     (cpu_pc),
        .cpu_rst_n  (cpu_rst_n),
        .fetch_err  (fetch_err),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Memory model and activity counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            wlog.push_back({mem_waddr, mem_wdata});
            tbMem[mem_waddr] = mem_wdata;
        end
        if (s_ready) readyCycles++;
        if (done) doneCount++;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".s_ready"},   32'(s_ready),   32'd0);
        checkOutput({tag, ".mem_we"},    32'(mem_we),    32'd0);
        checkOutput({tag, ".mem_waddr"}, 32'(mem_waddr), 32'd0);
        checkOutput({tag, ".mem_wdata"}, 32'(mem_wdata), 32'd0);
        checkOutput({tag, ".cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
        checkOutput({tag, ".fetch_err"}, 32'(fetch_err), 32'd0);
        checkOutput({tag, ".busy"},      32'(busy),      32'd0);
        checkOutput({tag, ".done"},      32'(done),      32'd0);
    endtask

    // Expected log: 256 zero writes at 0..255, then nLoad pattern bytes at 0..nLoad-1.
    function automatic int contentErrors(input int nLoad);
        int errs = 0;
        for (int i = 0; i < 256; i++) begin
            if (i >= wlog.size() || wlog[i] !== {8'(i), 8'h00}) errs++;
        end
        for (int j = 0; j < nLoad; j++) begin
            if (256 + j >= wlog.size() || wlog[256 + j] !== {8'(j), pat[j]}) errs++;
        end
        return errs;
    endfunction

    // Starts a load and streams pattern bytes whenever s_ready is seen. Junk is offered
    // while not ready so any acceptance outside LOAD shows up in the write log.
    task automatic applyStimulus(input logic [8:0] len, input bit toggle, input int abortAfter,
                                 input int injectAt, output bit finished);
        int idx = 0;
        int cyc = 0;
        int ph = 0;
        bit injected = 0;
        bit v;
        @(negedge clk);
        #1;
        wlog.delete();
        readyCycles = 0;
        doneCount = 0;
        load_start = 1'b1;
        load_len = len;
        s_valid = 1'b1;
        s_data = 8'hEE;
        @(negedge clk);
        load_start = 1'b0;
        finished = 1'b0;
        while (cyc < 3000) begin
            if (done) begin
                finished = 1'b1;
                break;
            end
            if (abortAfter != 0 && idx == abortAfter) begin
                finished = 1'b1;
                break;
            end
            load_start = 1'b0;
            if (injectAt != 0 && (cyc == 100 || (idx == injectAt && !injected))) begin
                load_start = 1'b1;
                load_len = 9'd5;
                if (idx == injectAt) injected = 1;
            end
            if (s_ready) begin
                v = toggle ? ph[0] : 1'b1;
                ph++;
            end else begin
                v = 1'b1;
            end
            s_valid = v;
            s_data = s_ready ? pat[idx] : 8'hEE;
            if (v && s_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        cpuRstAtDone = cpu_rst_n;
        busyAtDone = busy;
        s_valid = 1'b0;
        load_start = 1'b0;
        @(negedge clk);
        cpuRstAfter = cpu_rst_n;
        busyAfter = busy;
        doneAfter = done;
        @(negedge clk);
    endtask

    task automatic applyFetch(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            cpu_pc = fetchVecs[i].pc;
            @(negedge clk);
            checkOutput($sformatf("fetch[%0d].pc=%0d", i, fetchVecs[i].pc),
                        32'(fetch_err), 32'(fetchVecs[i].expErr));
        end
        cpu_pc = 32'd0;
    endtask

    initial begin
        bit fin;
        int sz;

        for (int i = 0; i < 256; i++) begin
            pat[i] = 8'(i * 37 + 11);
            tbMem[i] = 8'hA5;
        end
        pat[32] = 8'hAF;
        pat[33] = 8'hE3;
        pat[34] = 8'h00;
        pat[35] = 8'h05;

        loadVecs[0] = '{len: 9'd8,   toggle: 1'b1, expLoadWrites: 8,   expReady: 16,  expLastAddr: 8'd7};
        loadVecs[1] = '{len: 9'd0,   toggle: 1'b0, expLoadWrites: 0,   expReady: 0,   expLastAddr: 8'd255};
        loadVecs[2] = '{len: 9'd300, toggle: 1'b0, expLoadWrites: 256, expReady: 256, expLastAddr: 8'd255};

        fetchVecs[0] = '{pc: 32'd0,   expErr: 1'b0};
        fetchVecs[1] = '{pc: 32'd16,  expErr: 1'b0};
        fetchVecs[2] = '{pc: 32'd252, expErr: 1'b0};
        fetchVecs[3] = '{pc: 32'd18,  expErr: 1'b1};
        fetchVecs[4] = '{pc: 32'd256, expErr: 1'b1};
        fetchVecs[5] = '{pc: 32'd16,  expErr: 1'b1};
        fetchVecs[6] = '{pc: 32'd252, expErr: 1'b0};
        fetchVecs[7] = '{pc: 32'd256, expErr: 1'b1};
        fetchVecs[8] = '{pc: 32'd4,   expErr: 1'b1};

        rst_n = 1'b0;
        load_start = 1'b0;
        load_len = 9'd0;
        s_valid = 1'b0;
        s_data = 8'h00;
        cpu_pc = 32'd0;
        repeat (3) @(negedge clk);
        checkReset("por");
        rst_n = 1'b1;

        // Full 36-byte load with valid held high throughout.
        applyStimulus(9'd36, 1'b0, 0, 0, fin);
        checkOutput("t1.finished", 32'(fin), 32'd1);
        checkOutput("t1.writes", wlog.size(), 32'd292);
        checkOutput("t1.contentErrs", 32'(contentErrors(36)), 32'd0);
        checkOutput("t1.doneCount", 32'(doneCount), 32'd1);
        checkOutput("t1.cpuRstAtDone", 32'(cpuRstAtDone), 32'd0);
        checkOutput("t1.busyAtDone", 32'(busyAtDone), 32'd1);
        checkOutput("t1.cpuRstAfter", 32'(cpuRstAfter), 32'd1);
        checkOutput("t1.busyAfter", 32'(busyAfter), 32'd0);
        checkOutput("t1.doneAfter", 32'(doneAfter), 32'd0);
        checkOutput("t1.word32", {tbMem[32], tbMem[33], tbMem[34], tbMem[35]}, 32'hAFE30005);
        checkOutput("t1.word36", {tbMem[36], tbMem[37], tbMem[38], tbMem[39]}, 32'h0);

        for (int v = 0; v < 3; v++) begin
            applyStimulus(loadVecs[v].len, loadVecs[v].toggle, 0, 0, fin);
            checkOutput($sformatf("vec%0d.finished", v), 32'(fin), 32'd1);
            checkOutput($sformatf("vec%0d.loadWrites", v), wlog.size() - 256,
                        32'(loadVecs[v].expLoadWrites));
            checkOutput($sformatf("vec%0d.readyCycles", v), 32'(readyCycles),
                        32'(loadVecs[v].expReady));
            checkOutput($sformatf("vec%0d.contentErrs", v),
                        32'(contentErrors(loadVecs[v].expLoadWrites)), 32'd0);
            checkOutput($sformatf("vec%0d.lastAddr", v),
                        (wlog.size() > 0) ? 32'(wlog[wlog.size() - 1][15:8]) : 32'hFFFF_FFFF,
                        32'(loadVecs[v].expLastAddr));
            checkOutput($sformatf("vec%0d.doneCount", v), 32'(doneCount), 32'd1);
            checkOutput($sformatf("vec%0d.cpuRstAfter", v), 32'(cpuRstAfter), 32'd1);
        end

        // Fetch policing in RUN, then reprogram request clears the sticky flag.
        applyFetch(0, 5);
        load_start = 1'b1;
        load_len = 9'd4;
        @(negedge clk);
        load_start = 1'b0;
        checkOutput("t4.fetchErrCleared", 32'(fetch_err), 32'd0);
        checkOutput("t4.cpuRstLow", 32'(cpu_rst_n), 32'd0);
        checkOutput("t4.busy", 32'(busy), 32'd1);
        checkOutput("t4.clearWrite", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        checkReset("t4rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-LOAD after 10 bytes: outputs drop at once and writes stop.
        applyStimulus(9'd20, 1'b0, 10, 0, fin);
        checkOutput("t5.abortReached", 32'(fin), 32'd1);
        checkOutput("t5.writesBeforeReset", wlog.size(), 32'd266);
        checkOutput("t5.contentErrs", 32'(contentErrors(10)), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkReset("t5rst");
        sz = wlog.size();
        repeat (5) @(negedge clk);
        checkOutput("t5.noWritesInReset", wlog.size(), 32'(sz));
        checkOutput("t5.cpuHeld", 32'(cpu_rst_n), 32'd0);
        rst_n = 1'b1;

        // load_start during CLEAR and LOAD must not alter the programmed length.
        applyStimulus(9'd12, 1'b0, 0, 5, fin);
        checkOutput("t5b.finished", 32'(fin), 32'd1);
        checkOutput("t5b.loadWrites", wlog.size() - 256, 32'd12);
        checkOutput("t5b.contentErrs", 32'(contentErrors(12)), 32'd0);
        checkOutput("t5b.doneCount", 32'(doneCount), 32'd1);
        checkOutput("t5b.cpuRstAfter", 32'(cpuRstAfter), 32'd1);

        applyFetch(6, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
